// File: rtl/stepper_axis_ctrl.sv
// stepper_axis_ctrl: N-axis stepper homing/move core with shared command port and position readback
module stepper_axis_ctrl #(
  parameter int N_AXIS = 6,
  parameter int AXIS_W = 3,
  parameter int POS_W = 10,
  parameter int POS_MAX = 999,
  parameter int PULSE_DIV = 100,
  parameter int HOME_MAX = 1023
) (
  input logic sysclk,
  input logic rst,
  input logic [N_AXIS-1:0] Stop,
  input logic cmd_valid,
  output logic cmd_ready,
  input logic [AXIS_W-1:0] cmd_axis,
  input logic cmd_home,
  input logic [POS_W-1:0] cmd_pos,
  output logic cmd_err,
  output logic [N_AXIS-1:0] PU,
  output logic [N_AXIS-1:0] DR,
  output logic [N_AXIS-1:0] MF,
  output logic [N_AXIS-1:0] busy,
  output logic [N_AXIS-1:0] homed,
  output logic [N_AXIS-1:0] fault,
  input logic [AXIS_W-1:0] rd_axis,
  output logic [POS_W-1:0] rd_pos
);
  localparam int PH_W = $clog2(PULSE_DIV);
  localparam int HC_W = $clog2(HOME_MAX + 1);
  typedef enum logic [1:0] {HOMING, IDLE, MOVE, FAULT} state_t;
  logic rdy_q, rdy_d, err_q, err_d, bad;
  logic [N_AXIS-1:0] s1_q, s1_d, s2_q, s2_d, oh, sel;
  logic [POS_W-1:0] rd_q, rd_d, tgt_c;
  logic [POS_W-1:0] pos_a [N_AXIS];
  always_comb begin
    rdy_d = 1'b1;
    s1_d = Stop;
    s2_d = s1_q;
    oh = '0;
    for (int i = 0; i < N_AXIS; i++) oh[i] = cmd_axis == AXIS_W'(i);
    bad = ~|oh | |(oh & busy) | (~cmd_home & ~|(oh & homed));
    err_d = cmd_valid & cmd_ready & bad;
    sel = (cmd_valid & cmd_ready & ~bad) ? oh : '0;
    tgt_c = cmd_pos > POS_W'(POS_MAX) ? POS_W'(POS_MAX) : cmd_pos;
    rd_d = '0;
    for (int i = 0; i < N_AXIS; i++) if (rd_axis == AXIS_W'(i)) rd_d = pos_a[i];
  end
  always_ff @(posedge sysclk)
    if (!rst) begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      rd_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      err_q <= err_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      rd_q <= rd_d;
    end
  assign cmd_ready = rdy_q & rst;
  assign cmd_err = err_q;
  assign rd_pos = rd_q;
  for (genvar g = 0; g < N_AXIS; g++) begin : g_axis
    state_t st_q, st_d;
    logic [POS_W-1:0] pos_q, pos_d, tgt_q, tgt_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [HC_W-1:0] hc_q, hc_d;
    logic dr_q, dr_d, homed_q, homed_d, run, step, hit;
    always_comb begin
      run = st_q == HOMING || st_q == MOVE;
      step = run && ph_q == PH_W'(PULSE_DIV - 1);
      hit = s2_q[g] && (st_q == HOMING || (st_q == MOVE && !dr_q));
      st_d = st_q;
      pos_d = pos_q;
      tgt_d = tgt_q;
      dr_d = dr_q;
      hc_d = hc_q;
      homed_d = homed_q;
      ph_d = run ? (step ? '0 : ph_q + 1'b1) : PH_W'(PULSE_DIV - 1);
      case (st_q)
        HOMING:
          if (hit) begin
            st_d = IDLE;
            pos_d = '0;
            homed_d = 1'b1;
            ph_d = PH_W'(PULSE_DIV - 1);
          end else if (hc_q == HC_W'(HOME_MAX) && ph_q == PH_W'(PULSE_DIV - 2)) begin
            st_d = FAULT;
            homed_d = 1'b0;
          end else if (step && hc_q != HC_W'(HOME_MAX)) hc_d = hc_q + 1'b1;
        IDLE:
          if (sel[g] && cmd_home) begin
            st_d = HOMING;
            hc_d = '0;
            homed_d = 1'b0;
          end else if (sel[g] && tgt_c != pos_q) begin
            st_d = MOVE;
            tgt_d = tgt_c;
            dr_d = tgt_c > pos_q;
          end
        MOVE:
          if (hit) begin
            st_d = IDLE;
            pos_d = '0;
            ph_d = PH_W'(PULSE_DIV - 1);
          end else if (pos_q == tgt_q && ph_q == PH_W'(PULSE_DIV - 2)) st_d = IDLE;
          else if (step && pos_q != tgt_q)
            pos_d = dr_q ? (pos_q >= POS_W'(POS_MAX) ? pos_q : pos_q + 1'b1)
                         : (pos_q == '0 ? pos_q : pos_q - 1'b1);
        default:
          if (sel[g] && cmd_home) begin
            st_d = HOMING;
            hc_d = '0;
          end
      endcase
    end
    always_ff @(posedge sysclk)
      if (!rst) begin
        st_q <= HOMING;
        pos_q <= '0;
        tgt_q <= '0;
        ph_q <= PH_W'(PULSE_DIV - 1);
        hc_q <= '0;
        dr_q <= 1'b0;
        homed_q <= 1'b0;
      end else begin
        st_q <= st_d;
        pos_q <= pos_d;
        tgt_q <= tgt_d;
        ph_q <= ph_d;
        hc_q <= hc_d;
        dr_q <= dr_d;
        homed_q <= homed_d;
      end
    assign PU[g] = run && ph_q < PH_W'(PULSE_DIV / 2) && !hit;
    assign DR[g] = st_q == MOVE && dr_q;
    assign MF[g] = !run;
    assign busy[g] = run;
    assign homed[g] = homed_q;
    assign fault[g] = st_q == FAULT;
    assign pos_a[g] = pos_q;
  end
endmodule
